// File: rtl/p2_grms_usart_tx.sv
// p2_grms_usart_tx: Avalon-MM slave UART transmitter (8N1) with a byte FIFO.
// Ports:
//   clk, reset_n       - clock; synchronous active-low reset
//   address/chipselect/write_n/writedata - Avalon-MM write port
//   readdata           - combinational read data selected by address
//   tx_enable          - gates popping of new frames from the FIFO
//   txd                - registered serial output, idle high
//   tx_busy            - high while a frame is on the line
// Register map: 0 = TX data (write), 1 = status, 2 = overflow clear, 3 = divisor.
module p2_grms_usart_tx #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic        tx_enable,
  output logic [31:0] readdata,
  output logic        txd,
  output logic        tx_busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [4:0]      count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     div_q, div_d;
  logic [15:0]     bitdiv_q, bitdiv_d;
  logic [15:0]     baud_q, baud_d;
  logic [2:0]      bitidx_q, bitidx_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;

  logic wr, push, pop, fifo_empty, fifo_full, bit_end;

  assign wr         = chipselect & ~write_n;
  assign fifo_empty = (count_q == 5'd0);
  assign fifo_full  = (count_q == FIFO_DEPTH[4:0]);
  // Full is judged on the pre-edge count, so a same-edge pop never rescues a push.
  assign push       = wr && (address == 2'd0) && !fifo_full;
  assign bit_end    = (baud_q == bitdiv_q - 16'd1);

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    div_d    = div_q;
    bitdiv_d = bitdiv_q;
    baud_d   = baud_q;
    bitidx_d = bitidx_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    pop      = 1'b0;

    // Overflow set takes priority over a clear on the same edge.
    if (wr && (address == 2'd0) && fifo_full) begin
      ovf_d = 1'b1;
    end else if (wr && (address == 2'd2) && writedata[0]) begin
      ovf_d = 1'b0;
    end

    if (wr && (address == 2'd3)) begin
      div_d = (writedata[15:0] < 16'd2) ? 16'd2 : writedata[15:0];
    end

    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (tx_enable && !fifo_empty) pop = 1'b1;
      end
      START: begin
        baud_d = baud_q + 16'd1;
        if (bit_end) begin
          state_d  = DATA;
          baud_d   = '0;
          bitidx_d = '0;
          txd_d    = shift_q[0];
        end
      end
      DATA: begin
        baud_d = baud_q + 16'd1;
        if (bit_end) begin
          baud_d = '0;
          if (bitidx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            // The shifter moves one place per bit so bit 1 is always next.
            shift_d  = shift_q >> 1;
            txd_d    = shift_q[1];
            bitidx_d = bitidx_q + 3'd1;
          end
        end
      end
      STOP: begin
        baud_d = baud_q + 16'd1;
        if (bit_end) begin
          baud_d  = '0;
          state_d = IDLE;
          txd_d   = 1'b1;
          if (tx_enable && !fifo_empty) pop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      state_d  = START;
      shift_d  = mem_q[rptr_q];
      rptr_d   = rptr_q + AW'(1);
      bitdiv_d = div_q;
      baud_d   = '0;
      txd_d    = 1'b0;
    end

    if (push) wptr_d = wptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= CLK_DIV[15:0];
      bitdiv_q <= CLK_DIV[15:0];
      baud_q   <= '0;
      bitidx_q <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
      bitdiv_q <= bitdiv_d;
      baud_q   <= baud_d;
      bitidx_q <= bitidx_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push) mem_q[wptr_q] <= writedata[7:0];
  end

  assign tx_busy = (state_q != IDLE);
  assign txd     = txd_q;

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd1:    readdata = {23'd0, count_q, ovf_q, tx_busy, fifo_full, fifo_empty};
      2'd3:    readdata = {16'd0, div_q};
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_p2_grms_usart_tx.sv
// tb_p2_grms_usart_tx: directed self-checking bench for p2_grms_usart_tx.
module tb_p2_grms_usart_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic        tx_enable = 1'b0;
  logic [31:0] readdata;
  logic        txd;
  logic        tx_busy;

  int unsigned total = 0;
  int unsigned bad = 0;

  p2_grms_usart_tx #(.CLK_DIV(434), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .tx_enable(tx_enable),
    .readdata(readdata), .txd(txd), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  task automatic do_reset();
    tx_enable = 1'b0;
    chipselect = 1'b0;
    write_n = 1'b1;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Expected txd for position p (clocks) within a frame of byte b with bit period d.
  function automatic logic frame_bit(input logic [7:0] b, input int p, input int d);
    int idx;
    idx = p / d;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  initial begin
    logic [9:0] seq_a5;
    logic [7:0] b1;
    int busy_run;
    seq_a5 = 10'b1101001010;

    vecs[0]  = '{1'b0, 2'd0, 32'h0,     2'd3, 32'd434};
    vecs[1]  = '{1'b0, 2'd0, 32'h0,     2'd1, 32'h001};
    vecs[2]  = '{1'b0, 2'd0, 32'h0,     2'd2, 32'h000};
    vecs[3]  = '{1'b1, 2'd3, 32'h0,     2'd3, 32'h002};
    vecs[4]  = '{1'b1, 2'd3, 32'h1,     2'd3, 32'h002};
    vecs[5]  = '{1'b1, 2'd3, 32'h12345, 2'd3, 32'h2345};
    vecs[6]  = '{1'b1, 2'd3, 32'h4,     2'd3, 32'h004};
    vecs[7]  = '{1'b1, 2'd0, 32'h55,    2'd1, 32'h010};
    vecs[8]  = '{1'b1, 2'd0, 32'h166,   2'd1, 32'h020};
    vecs[9]  = '{1'b1, 2'd2, 32'h1,     2'd1, 32'h020};
    vecs[10] = '{1'b0, 2'd0, 32'h0,     2'd2, 32'h000};

    do_reset();
    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_busy", {31'd0, tx_busy}, 32'd0);
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].waddr, vecs[i].wdata);
      else tick();
      read_check($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
    end

    // Single frame 0xA5 at divisor 4.
    do_reset();
    bus_write(2'd3, 32'd4);
    tx_enable = 1'b1;
    bus_write(2'd0, 32'hA5);
    check("a5_pre_txd", {31'd0, txd}, 32'd1);
    busy_run = 0;
    for (int k = 0; k < 44; k++) begin
      tick();
      if (tx_busy) busy_run++;
      check($sformatf("a5_txd_k%0d", k), {31'd0, txd}, (k < 40) ? {31'd0, seq_a5[k/4]} : 32'd1);
    end
    check("a5_busy_clocks", busy_run, 32'd40);

    // Overflow with tx disabled.
    do_reset();
    for (int i = 0; i < 9; i++) bus_write(2'd0, 32'(i));
    read_check("ovf_status", 2'd1, 32'h08A);
    check("ovf_txd", {31'd0, txd}, 32'd1);
    bus_write(2'd2, 32'd1);
    read_check("ovf_clear", 2'd1, 32'h082);
    // Push to full FIFO on the same edge as a pop is still dropped.
    tx_enable = 1'b1;
    bus_write(2'd0, 32'h77);
    tx_enable = 1'b0;
    read_check("full_pop_push", 2'd1, 32'h07C);

    // Back-to-back frames at divisor 2.
    do_reset();
    bus_write(2'd3, 32'd2);
    bus_write(2'd0, 32'h00);
    bus_write(2'd0, 32'hFF);
    tx_enable = 1'b1;
    busy_run = 0;
    for (int k = 0; k < 45; k++) begin
      tick();
      if (tx_busy) busy_run++;
      b1 = (k < 20) ? 8'h00 : 8'hFF;
      check($sformatf("b2b_txd_k%0d", k), {31'd0, txd},
            (k < 40) ? {31'd0, frame_bit(b1, k % 20, 2)} : 32'd1);
    end
    check("b2b_busy_clocks", busy_run, 32'd40);

    // tx_enable dropped mid-frame.
    do_reset();
    bus_write(2'd3, 32'd2);
    bus_write(2'd0, 32'h0F);
    bus_write(2'd0, 32'hF0);
    tx_enable = 1'b1;
    for (int k = 0; k < 26; k++) begin
      tick();
      if (k == 4) tx_enable = 1'b0;
      check($sformatf("drop_txd_k%0d", k), {31'd0, txd},
            (k < 20) ? {31'd0, frame_bit(8'h0F, k, 2)} : 32'd1);
      check($sformatf("drop_busy_k%0d", k), {31'd0, tx_busy}, (k < 20) ? 32'd1 : 32'd0);
    end
    read_check("drop_count", 2'd1, 32'h010);
    tx_enable = 1'b1;
    tick();
    check("resume_txd", {31'd0, txd}, 32'd0);
    read_check("resume_status", 2'd1, 32'h005);

    // Reset mid-frame.
    do_reset();
    bus_write(2'd3, 32'd4);
    bus_write(2'd0, 32'hA5);
    bus_write(2'd0, 32'h3C);
    tx_enable = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("mid_busy_before", {31'd0, tx_busy}, 32'd1);
    reset_n = 1'b0;
    tick();
    check("mid_rst_txd", {31'd0, txd}, 32'd1);
    check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
    read_check("mid_rst_status", 2'd1, 32'h001);
    read_check("mid_rst_div", 2'd3, 32'd434);
    reset_n = 1'b1;
    tx_enable = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/p2_grms_usart_tx.md
P2_GRMS_USART_TX -- requirements
Module: p2_grms_usart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434, meaning reset value of the baud divisor (clocks per bit; 50 MHz / 115200).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning the transmit FIFO depth in bytes (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port address, input, 2 bits: Avalon-MM register select.
REQ-006 SHALL have port chipselect, input, 1 bit: Avalon-MM slave select.
REQ-007 SHALL have port write_n, input, 1 bit: Avalon-MM write strobe, active-low.
REQ-008 SHALL have port writedata, input, 32 bits: Avalon-MM write data.
REQ-009 SHALL have port tx_enable, input, 1 bit: transmit enable, driven by the upstream 1-bit PIO out_port.
REQ-010 SHALL have port readdata, output, 32 bits: Avalon-MM read data, combinational from address, zero-latency.
REQ-011 SHALL have port txd, output, 1 bit: serial line, 8N1, idle high.
REQ-012 SHALL have port tx_busy, output, 1 bit: high while a frame is on the line.

Function
REQ-013 SHALL define a write as chipselect=1 and write_n=0 at a clock edge; no read strobe; readdata SHALL depend only on address and register state.
REQ-014 SHALL, on a write to address 0, push writedata[7:0] into the FIFO when not full; when full, SHALL drop the byte and set the sticky overflow flag.
REQ-015 SHALL evaluate "full" against the pre-edge count: a push to a full FIFO is dropped even if a pop occurs on the same edge.
REQ-016 SHALL return status on read of address 1: bit0 empty, bit1 full, bit2 tx_busy, bit3 overflow, bits[8:4] FIFO count (0..FIFO_DEPTH); all other bits 0.
REQ-017 SHALL clear overflow on a write to address 2 with writedata[0]=1; a same-edge overflow event SHALL win and leave the flag set. Address 2 SHALL read as 0.
REQ-018 SHALL hold a 16-bit divisor at address 3 (read/write, bits[15:0]); written values below 2 SHALL be stored as 2.
REQ-019 SHALL implement states IDLE, START, DATA, STOP; tx_busy=1 in every state except IDLE.
REQ-020 SHALL, in IDLE with tx_enable=1 and FIFO not empty, on the next edge: pop the head into the shift register, latch the divisor as the frame bit period, enter START, and drive txd=0.
REQ-021 SHALL hold START for one bit period, then shift 8 data bits LSB first with one bit period each (DATA), then drive txd=1 for one bit period (STOP).
REQ-022 SHALL, at the end of STOP, go directly to START (no idle cycle) if tx_enable=1 and FIFO not empty; otherwise go to IDLE.
REQ-023 SHALL let a frame in progress complete when tx_enable falls mid-frame; no new pop SHALL occur while tx_enable=0.
REQ-024 SHALL make a divisor write take effect at the next frame start only.
REQ-025 SHALL make a byte pushed into an empty FIFO available for popping no earlier than the following edge.
REQ-026 SHALL drive txd from a register (glitch-free) and high in IDLE.

Reset
REQ-027 SHALL, on reset_n=0 at a clock edge: state IDLE, txd=1, tx_busy=0, FIFO empty (count 0), overflow=0, divisor=CLK_DIV, readdata reflecting those values.
REQ-028 SHALL abort any frame in progress on reset, returning txd to 1 on the same edge.

Verification
REQ-029 SHALL verify: reset, then read address 3 -> 434; read address 1 -> 0x001 (empty).
REQ-030 SHALL verify: divisor=4, tx_enable=1, write 0xA5 to address 0 -> txd sequence 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; tx_busy high for exactly 40 clocks.
REQ-031 SHALL verify: tx_enable=0, write 9 bytes -> count 8, full=1, overflow=1, txd stays 1; write 1 to address 2 -> overflow=0.
REQ-032 SHALL verify: divisor=2, two bytes queued, tx_enable=1 -> second START immediately follows first STOP; 40 consecutive busy clocks.
REQ-033 SHALL verify: tx_enable dropped during DATA of byte 1 with byte 2 queued -> byte 1 completes, IDLE, count stays 1 until tx_enable returns.
REQ-034 SHALL verify: reset_n pulsed low mid-DATA -> txd=1, tx_busy=0, count 0 after that edge.
